instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 11 +
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: the fetch unit drives the request and address,
// and memory returns an ack together with the instruction word.
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, addr, input ack, data);
    modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: FETCH -> WAIT -> EXEC loop with next-PC selection
// from decoder controls, halting on decode errors or memory timeouts.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       en,
    instruction_fetch_if.master        imem,
    output logic [31:0]                I,
    output logic                       I_VALID,
    input  logic                       BR_PC,
    input  logic                       BR_PC_COND,
    input  logic                       IF_NEXT_PC,
    input  logic [3:0]                 PSTATE_COND,
    input  logic [3:0]                 FLAGS,
    input  logic [3:0]                 decode_err,
    output logic [31:0]                PC,
    output logic                       HALTED,
    output logic [1:0]                 FAULT
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [31:0]        pc_next;
    logic [31:0]        instr_next;
    logic [1:0]         fault_next;
    logic [CNT_W-1:0]   wait_cnt, cnt_next;
    logic signed [31:0] br_off;
    logic signed [31:0] cond_off;

    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return c && !z;
            4'b1001: return !c || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Word offsets: 26-bit immediate for BR_PC, 19-bit field I[23:5] for conditional
    assign br_off   = {{4{I[25]}}, I[25:0], 2'b00};
    assign cond_off = {{11{I[23]}}, I[23:5], 2'b00};

    assign imem.addr = PC;
    assign HALTED    = (state == HALT);

    always_comb begin
        state_next = state;
        pc_next    = PC;
        instr_next = I;
        fault_next = FAULT;
        cnt_next   = wait_cnt;
        imem.req   = 1'b0;
        I_VALID    = 1'b0;
        case (state)
            FETCH: begin
                if (en) begin
                    imem.req   = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    instr_next = imem.data;
                    state_next = EXEC;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_next = 2'b10;
                    state_next = HALT;
                end else begin
                    cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            EXEC: begin
                I_VALID = 1'b1;
                if (decode_err != 4'h0) begin
                    fault_next = 2'b01;
                    state_next = HALT;
                end else begin
                    state_next = FETCH;
                    if (BR_PC)
                        pc_next = PC + br_off;
                    else if (BR_PC_COND && cond_true(PSTATE_COND, FLAGS))
                        pc_next = PC + cond_off;
                    else if (IF_NEXT_PC || BR_PC_COND)
                        pc_next = PC + 32'd4;
                end
            end
            HALT: ;
            default: state_next = FETCH;
        endcase
        // Reset abandons any request or valid pulse in the same cycle
        if (RESET) begin
            imem.req = 1'b0;
            I_VALID  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= FETCH;
            PC       <= RESET_PC;
            I        <= '0;
            FAULT    <= 2'b00;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            PC       <= pc_next;
            I        <= instr_next;
            FAULT    <= fault_next;
            wait_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table of fetch/exec vectors with
// hand-computed next PCs, plus sequences for halt, timeout, and reset corners.
module tb_instruction_fetch;

    logic        CLK;
    logic        RESET;
    logic        en;
    logic [31:0] I;
    logic        I_VALID;
    logic        BR_PC, BR_PC_COND, IF_NEXT_PC;
    logic [3:0]  PSTATE_COND, FLAGS, decode_err;
    logic [31:0] PC;
    logic        HALTED;
    logic [1:0]  FAULT;

    int checks = 0;
    int errors = 0;

    instruction_fetch_if imem ();

    instruction_fetch dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .en         (en),
        .imem       (imem),
        .I          (I),
        .I_VALID    (I_VALID),
        .BR_PC      (BR_PC),
        .BR_PC_COND (BR_PC_COND),
        .IF_NEXT_PC (IF_NEXT_PC),
        .PSTATE_COND(PSTATE_COND),
        .FLAGS      (FLAGS),
        .decode_err (decode_err),
        .PC         (PC),
        .HALTED     (HALTED),
        .FAULT      (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        brc;
        logic        nxt;
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [18];
    logic [31:0] exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_dec();
        BR_PC       = 1'b0;
        BR_PC_COND  = 1'b0;
        IF_NEXT_PC  = 1'b0;
        PSTATE_COND = 4'h0;
        FLAGS       = 4'h0;
        decode_err  = 4'h0;
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge of the next FETCH.
    task automatic run_vec(input vec_t v, input int idx);
        en = 1'b1;
        #1;
        chk($sformatf("v%0d fetch_req", idx), 32'(imem.req), 32'd1);
        chk($sformatf("v%0d fetch_addr", idx), imem.addr, exp_addr);
        chk($sformatf("v%0d fetch_ivalid", idx), 32'(I_VALID), 32'd0);
        @(negedge CLK);
        chk($sformatf("v%0d wait_req", idx), 32'(imem.req), 32'd1);
        chk($sformatf("v%0d wait_ivalid", idx), 32'(I_VALID), 32'd0);
        imem.ack  = 1'b1;
        imem.data = v.instr;
        @(negedge CLK);
        imem.ack    = 1'b0;
        imem.data   = 32'h0;
        chk($sformatf("v%0d exec_ivalid", idx), 32'(I_VALID), 32'd1);
        chk($sformatf("v%0d exec_I", idx), I, v.instr);
        BR_PC       = v.br;
        BR_PC_COND  = v.brc;
        IF_NEXT_PC  = v.nxt;
        PSTATE_COND = v.cond;
        FLAGS       = v.flags;
        @(negedge CLK);
        clear_dec();
        chk($sformatf("v%0d next_pc", idx), PC, v.exp_pc);
        exp_addr = v.exp_pc;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        en    = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
    endtask

    initial begin
        //            instr          br    brc   nxt   cond     flags    exp_pc
        vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0004};
        vecs[1]  = '{32'h1234_5678, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_000C};
        vecs[3]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0010};
        vecs[4]  = '{32'h03FF_FFFE, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0008};
        vecs[5]  = '{32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 32'h0000_0018};
        vecs[6]  = '{32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0000_001C};
        vecs[7]  = '{32'h0000_0080, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 32'h0000_001C};
        vecs[8]  = '{32'h0000_0010, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_005C};
        vecs[9]  = '{32'h0000_0020, 1'b1, 1'b1, 1'b1, 4'b1110, 4'b0000, 32'h0000_00DC};
        vecs[10] = '{32'h00FF_FFE0, 1'b0, 1'b1, 1'b0, 4'b1010, 4'b1001, 32'h0000_00D8};
        vecs[11] = '{32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0110, 32'h0000_00DC};
        vecs[12] = '{32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b0000, 32'h0000_00EC};
        vecs[13] = '{32'h0000_0040, 1'b0, 1'b1, 1'b0, 4'b1011, 4'b1000, 32'h0000_00F4};
        vecs[14] = '{32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0000, 32'h0000_00F8};
        vecs[15] = '{32'h0000_0080, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 32'h0000_00FC};
        vecs[16] = '{32'h03FF_FFC0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'hFFFF_FFFC};
        vecs[17] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000};

        imem.ack  = 1'b0;
        imem.data = 32'h0;
        clear_dec();
        do_reset();

        chk("rst_pc", PC, 32'h0);
        chk("rst_I", I, 32'h0);
        chk("rst_ivalid", 32'(I_VALID), 32'd0);
        chk("rst_req", 32'(imem.req), 32'd0);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_fault", 32'(FAULT), 32'd0);

        exp_addr = 32'h0;
        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Decode error in EXEC halts with PC unchanged and no further requests
        en = 1'b1;
        @(negedge CLK);
        imem.ack  = 1'b1;
        imem.data = 32'hCAFE_0001;
        @(negedge CLK);
        imem.ack   = 1'b0;
        decode_err = 4'h3;
        IF_NEXT_PC = 1'b1;
        @(negedge CLK);
        clear_dec();
        chk("derr_halted", 32'(HALTED), 32'd1);
        chk("derr_fault", 32'(FAULT), 32'd1);
        chk("derr_pc", PC, 32'h0);
        imem.ack  = 1'b1;
        imem.data = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("halt_req", 32'(imem.req), 32'd0);
            chk("halt_ivalid", 32'(I_VALID), 32'd0);
            chk("halt_I", I, 32'hCAFE_0001);
            chk("halt_pc", PC, 32'h0);
        end
        imem.ack = 1'b0;

        do_reset();
        chk("rst2_halted", 32'(HALTED), 32'd0);
        chk("rst2_fault", 32'(FAULT), 32'd0);
        chk("rst2_I", I, 32'h0);
        @(negedge CLK);
        chk("en0_hold_req", 32'(imem.req), 32'd0);

        // Memory never answers: 15 WAIT cycles then timeout halt
        en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            chk($sformatf("to_wait%0d_req", k), 32'(imem.req), 32'd1);
            chk($sformatf("to_wait%0d_halted", k), 32'(HALTED), 32'd0);
        end
        @(negedge CLK);
        chk("to_halted", 32'(HALTED), 32'd1);
        chk("to_fault", 32'(FAULT), 32'd2);
        chk("to_req", 32'(imem.req), 32'd0);

        do_reset();

        // Ack arrives on the last permitted WAIT cycle
        en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (k == 14) begin
                imem.ack  = 1'b1;
                imem.data = 32'hA5A5_0014;
            end
        end
        @(negedge CLK);
        imem.ack   = 1'b0;
        chk("late_ivalid", 32'(I_VALID), 32'd1);
        chk("late_halted", 32'(HALTED), 32'd0);
        chk("late_I", I, 32'hA5A5_0014);
        IF_NEXT_PC = 1'b1;
        @(negedge CLK);
        clear_dec();
        chk("late_pc", PC, 32'h4);
        chk("late_fault", 32'(FAULT), 32'd0);

        // Ack in FETCH with en low is ignored
        en        = 1'b0;
        imem.ack  = 1'b1;
        imem.data = 32'hDEAD_BEEF;
        #1;
        chk("idle_req", 32'(imem.req), 32'd0);
        @(negedge CLK);
        chk("idle_ack_I", I, 32'hA5A5_0014);
        chk("idle_ack_ivalid", 32'(I_VALID), 32'd0);

        // en dropped mid-flight still completes; ack in EXEC ignored
        imem.ack = 1'b0;
        en       = 1'b1;
        @(negedge CLK);
        en        = 1'b0;
        imem.ack  = 1'b1;
        imem.data = 32'h1111_1111;
        @(negedge CLK);
        chk("enlow_ivalid", 32'(I_VALID), 32'd1);
        chk("enlow_I", I, 32'h1111_1111);
        imem.data  = 32'h2222_2222;
        IF_NEXT_PC = 1'b1;
        @(negedge CLK);
        clear_dec();
        imem.ack = 1'b0;
        chk("enlow_pc", PC, 32'h8);
        chk("exec_ack_I", I, 32'h1111_1111);
        chk("enlow_fetch_req", 32'(imem.req), 32'd0);

        // Reset during WAIT with a simultaneous ack
        en = 1'b1;
        @(negedge CLK);
        chk("rw_wait_req", 32'(imem.req), 32'd1);
        RESET     = 1'b1;
        imem.ack  = 1'b1;
        imem.data = 32'h3333_3333;
        @(negedge CLK);
        chk("rw_pc", PC, 32'h0);
        chk("rw_I", I, 32'h0);
        chk("rw_ivalid", 32'(I_VALID), 32'd0);
        chk("rw_halted", 32'(HALTED), 32'd0);
        RESET    = 1'b0;
        imem.ack = 1'b0;
        en       = 1'b1;
        #1;
        chk("rw_fetch_req", 32'(imem.req), 32'd1);
        chk("rw_fetch_addr", imem.addr, 32'h0);
        @(negedge CLK);
        chk("rw_then_wait_ivalid", 32'(I_VALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
